uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: idle-hold limit, used only when UART_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 req_last  input  NUM_REQ  byte is final byte of the packet; qualified with req_valid.
REQ-008 req_ready  output  NUM_REQ  byte consumed this cycle.
REQ-009 trmt  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 tx_data  output  8  byte presented to the UART; stable while trmt is high.
REQ-011 tx_done  input  1  UART done flag: cleared the cycle after trmt, set when the frame completes, then held.
REQ-012 grant_id  output  $clog2(NUM_REQ)  index of the current owner.
REQ-013 busy  output  1  a packet owns the transmitter.
REQ-014 pkt_abort  output  1  one-cycle pulse when a packet is abandoned by timeout.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT and HOLD.
REQ-016 IDLE: when any req_valid is high, select the first valid index at or above rr_ptr (circular), latch it into grant_id, set busy, and go to ISSUE; otherwise stay in IDLE.
REQ-017 ISSUE, exactly one cycle: req_ready[grant_id]=1; capture req_data and req_last of the granted requester; go to WAIT.
REQ-018 The captured byte SHALL appear on tx_data with trmt=1 in the first WAIT cycle (registered; 1-cycle latency from the accept edge).
REQ-019 trmt SHALL be high for exactly one cycle per byte.
REQ-020 WAIT: ignore tx_done while trmt=1; thereafter on tx_done=1, go to IDLE if the captured last=1, else to HOLD.
REQ-021 HOLD: when req_valid[grant_id]=1, go to ISSUE; req_valid of other requesters is ignored while a packet is open.
REQ-022 req_ready SHALL be 0 for every index except grant_id in ISSUE.
REQ-023 Requesters SHALL hold req_valid, req_data and req_last stable until req_ready; the block does not re-check valid in ISSUE.
REQ-024 On packet completion (last byte done, or abort), busy goes to 0 and rr_ptr <= (grant_id+1) mod NUM_REQ; the wrap from NUM_REQ-1 to 0 is required.
REQ-025 Zero-byte packets are impossible; a single byte with last=1 is a complete packet.
REQ-026 tx_data SHALL hold its last value between bytes; grant_id SHALL hold its value after busy falls.

Reset
REQ-027 Reset values: state=IDLE, trmt=0, tx_data=8'h00, req_ready=0, grant_id=0, busy=0, pkt_abort=0, rr_ptr=0, timeout counter=0.
REQ-028 Reset mid-packet SHALL abandon the packet immediately with no further trmt; the requester must restart the packet.

Configuration
REQ-029 With macro UART_ARB_TIMEOUT_EN defined: a counter clears on HOLD entry and increments each HOLD cycle without req_valid[grant_id].
REQ-030 At count TIMEOUT_CYCLES-1: go to IDLE, pulse pkt_abort for one cycle, clear busy, rotate rr_ptr.
REQ-031 Arrival of req_valid[grant_id] in the same cycle as the count reaching TIMEOUT_CYCLES-1 SHALL win; the block goes to ISSUE.
REQ-032 Without UART_ARB_TIMEOUT_EN: HOLD waits indefinitely, pkt_abort is tied to 0, and no counter logic is built.

Verification
REQ-033 Single requester 0 sends 3 bytes 0xA5,0x5A,0x3C with last on the 3rd -> three trmt pulses in order, tx_data matches each, busy falls after the 3rd tx_done, rr_ptr=1.
REQ-034 Requesters 0 and 2 valid together from reset -> 0 is served first; then 2; a second round with both valid serves 0 again after 2.
REQ-035 Requester 1 mid-packet while requester 3 is valid -> no req_ready[3] until requester 1's last byte completes.
REQ-036 tx_done held at 1 from the previous frame -> no second trmt until tx_done has fallen and risen again.
REQ-037 UART_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, requester 0 stalls after byte 1 -> pkt_abort pulses 16 HOLD cycles later, busy=0, rr_ptr=1.
REQ-038 rst asserted during WAIT -> all outputs return to their reset values asynchronously, and no trmt follows until a new request arrives.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter feeding one UART transmitter.
// Optional HOLD timeout with pkt_abort is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       trmt,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       pkt_abort
);
  localparam int GW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;
  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d, rr_q, rr_d, pick, idx, grant_nxt;
  logic            busy_q, busy_d, last_q, last_d, trmt_q, trmt_d, fin;
  logic [7:0]      data_q, data_d;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            abort_q, abort_d;
`endif
  // Lowest circular offset from rr_q wins, so scan offsets high to low.
  always_comb begin
    pick = rr_q;
    idx  = rr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = GW'((int'(rr_q) + i) % NUM_REQ);
      if (req_valid[idx]) pick = idx;
    end
  end
  assign grant_nxt = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    rr_d    = rr_q;
    data_d  = data_q;
    last_d  = last_q;
    trmt_d  = 1'b0;
    fin     = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    abort_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (|req_valid) begin
        grant_d = pick;
        busy_d  = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        data_d  = req_data[{grant_q, 3'b000} +: 8];
        last_d  = req_last[grant_q];
        trmt_d  = 1'b1;
        state_d = WAIT;
      end
      // tx_done is stale during the trmt cycle; the UART clears it one cycle later.
      WAIT: if (!trmt_q && tx_done) begin
        state_d = last_q ? IDLE : HOLD;
        fin     = last_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      HOLD: begin
        if (req_valid[grant_q]) state_d = ISSUE;
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          fin     = 1'b1;
          abort_d = 1'b1;
        end
        else cnt_d = cnt_q + 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      busy_d = 1'b0;
      rr_d   = grant_nxt;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      rr_q    <= '0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      trmt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      trmt_q  <= trmt_d;
    end
  end
`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end
  assign pkt_abort = abort_q;
`else
  assign pkt_abort = 1'b0;
`endif
  assign req_ready = (state_q == ISSUE) ? (NUM_REQ'(1) << grant_q) : '0;
  assign trmt      = trmt_q;
  assign tx_data   = data_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench with a behavioural UART and requester queues.
module tb_uart_tx_arbiter;
  localparam int N = 4, FRAME = 5;
  logic          clk = 1'b0, rst = 1'b1;
  logic [N-1:0]  req_valid = '0, req_last = '0, req_ready, rdy_s;
  logic [8*N-1:0] req_data = '0;
  logic          trmt, tx_done, busy, pkt_abort;
  logic [7:0]    tx_data;
  logic [1:0]    grant_id;
  logic [8:0]    bq [N][$];
  int            tl_d[$], tl_g[$], tl_c[$], rl[$];
  int            cyc = 0, fcnt = 0, aborts = 0, abort_cyc = 0, tests = 0, fails = 0, t = 0, a0 = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy), .pkt_abort(pkt_abort));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART: done clears the cycle after trmt, sets again FRAME cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_done <= 1'b1;
      fcnt    <= 0;
    end else if (trmt) begin
      tx_done <= 1'b0;
      fcnt    <= FRAME;
    end else if (fcnt != 0) begin
      fcnt <= fcnt - 1;
      if (fcnt == 1) tx_done <= 1'b1;
    end
  end

  initial forever begin
    @(posedge clk);
    rdy_s = req_ready;
    #1;
    for (int i = 0; i < N; i++) begin
      if (rdy_s[i] && bq[i].size() != 0) void'(bq[i].pop_front());
      req_valid[i] = bq[i].size() != 0;
      if (bq[i].size() != 0) {req_last[i], req_data[8*i +: 8]} = bq[i][0];
    end
  end

  initial forever begin
    @(negedge clk);
    if (trmt) begin
      tl_d.push_back(int'(tx_data));
      tl_g.push_back(int'(grant_id));
      tl_c.push_back(cyc);
    end
    if (|req_ready) rl.push_back(int'(req_ready));
    if (pkt_abort) begin
      aborts++;
      abort_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit bq_empty();
    for (int i = 0; i < N; i++) if (bq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(busy === 1'b0 && bq_empty()) && k < 400);
    check({tag, "_idle_in_time"}, 32'(k < 400), 1);
  endtask

  task automatic wait_trmt(input string tag, output int tc);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (trmt !== 1'b1 && k < 200);
    tc = cyc;
    check({tag, "_trmt_in_time"}, 32'(k < 200), 1);
  endtask

  task automatic clr_logs();
    tl_d.delete();
    tl_g.delete();
    tl_c.delete();
    rl.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_trmt", 32'(trmt), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_abort", 32'(pkt_abort), 0);
    rst = 1'b0;
    // Three-byte packet from requester 0.
    bq[0].push_back({1'b0, 8'hA5});
    bq[0].push_back({1'b0, 8'h5A});
    bq[0].push_back({1'b1, 8'h3C});
    wait_idle("pkt3");
    check("pkt3_count", tl_d.size(), 3);
    check("pkt3_b0", tl_d[0], 32'hA5);
    check("pkt3_b1", tl_d[1], 32'h5A);
    check("pkt3_b2", tl_d[2], 32'h3C);
    check("pkt3_gap01", tl_c[1] - tl_c[0], 9);
    check("pkt3_gap12", tl_c[2] - tl_c[1], 9);
    check("pkt3_ready_count", rl.size(), 3);
    check("pkt3_ready", rl[2], 1);
    check("pkt3_grant_held", 32'(grant_id), 0);
    // rr_ptr now 1: requester 1 beats requester 0.
    clr_logs();
    bq[0].push_back({1'b1, 8'h10});
    bq[1].push_back({1'b1, 8'h20});
    wait_idle("rr1");
    check("rr1_first_grant", tl_g[0], 1);
    check("rr1_first_data", tl_d[0], 32'h20);
    check("rr1_second_grant", tl_g[1], 0);
    // From reset, requesters 0 and 2 over two rounds.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr_logs();
    bq[0].push_back({1'b1, 8'h01});
    bq[2].push_back({1'b1, 8'h02});
    wait_idle("rr_a");
    bq[0].push_back({1'b1, 8'h03});
    bq[2].push_back({1'b1, 8'h04});
    wait_idle("rr_b");
    check("rr_count", tl_g.size(), 4);
    check("rr_g0", tl_g[0], 0);
    check("rr_g1", tl_g[1], 2);
    check("rr_g2", tl_g[2], 0);
    check("rr_g3", tl_g[3], 2);
    check("rr_d3", tl_d[3], 32'h04);
    // Requester 1 holds the transmitter while requester 3 waits.
    clr_logs();
    bq[1].push_back({1'b0, 8'h11});
    wait_trmt("own", t);
    bq[3].push_back({1'b1, 8'h33});
    repeat (20) @(negedge clk);
    check("own_ready_count_hold", rl.size(), 1);
    check("own_busy_hold", 32'(busy), 1);
    bq[1].push_back({1'b1, 8'h22});
    wait_idle("own");
    check("own_ready_count", rl.size(), 3);
    check("own_ready1", rl[1], 2);
    check("own_ready2", rl[2], 8);
    check("own_d1", tl_d[1], 32'h22);
    check("own_d2", tl_d[2], 32'h33);
    check("own_grant_held", 32'(grant_id), 3);
    // Asynchronous reset in the first WAIT cycle.
    clr_logs();
    bq[2].push_back({1'b0, 8'h77});
    bq[2].push_back({1'b1, 8'h78});
    wait_trmt("arst", t);
    #2 rst = 1'b1;
    #1;
    check("arst_trmt", 32'(trmt), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_grant", 32'(grant_id), 0);
    check("arst_tx_data", 32'(tx_data), 0);
    check("arst_req_ready", 32'(req_ready), 0);
    for (int i = 0; i < N; i++) bq[i].delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("arst_no_trmt", tl_d.size(), 1);
    bq[1].push_back({1'b1, 8'h99});
    wait_idle("arst_new");
    check("arst_new_data", tl_d[1], 32'h99);
    check("arst_new_grant", tl_g[1], 1);
`ifdef UART_ARB_TIMEOUT_EN
    clr_logs();
    bq[0].push_back({1'b0, 8'h55});
    wait_trmt("to", t);
    for (int k = 0; k < 60 && aborts == 0; k++) @(negedge clk);
    check("to_abort_seen", aborts, 1);
    check("to_abort_delay", abort_cyc - t, 23);
    check("to_busy", 32'(busy), 0);
    @(negedge clk);
    check("to_abort_pulse", 32'(pkt_abort), 0);
    clr_logs();
    bq[0].push_back({1'b1, 8'h56});
    bq[1].push_back({1'b1, 8'h57});
    wait_idle("to_rr");
    check("to_rr_grant", tl_g[0], 1);
    clr_logs();
    a0 = aborts;
    bq[3].push_back({1'b0, 8'h44});
    wait_trmt("tie", t);
    for (int k = 0; k < 60 && cyc < t + 21; k++) @(negedge clk);
    bq[3].push_back({1'b1, 8'h45});
    wait_idle("tie");
    check("tie_no_abort", aborts, a0);
    check("tie_count", tl_d.size(), 2);
    check("tie_data", tl_d[1], 32'h45);
`else
    clr_logs();
    bq[0].push_back({1'b0, 8'h55});
    wait_trmt("hold", t);
    repeat (40) @(negedge clk);
    check("hold_no_abort", aborts, 0);
    check("hold_busy", 32'(busy), 1);
    bq[0].push_back({1'b1, 8'h56});
    wait_idle("hold");
    check("hold_count", tl_d.size(), 2);
    check("hold_data", tl_d[1], 32'h56);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
